// File: rtl/time_entry_buffer.sv
// Keypad-to-timer front end: collects up to four BCD digits as MM:SS, normalizes
// seconds into minutes, parallel-loads the countdown timer and sequences run/pause/done.
module time_entry_buffer (
    input  logic       clk,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start_key,
    input  logic       stop_key,
    input  logic       timer_zero,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       load_n,
    output logic       enab,
    output logic       done,
    output logic [2:0] digit_count
);

    localparam int unsigned DIG_W  = 4;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned ST_W   = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_ENTRY = 3'd1;
    localparam logic [ST_W-1:0] ST_NORM  = 3'd2;
    localparam logic [ST_W-1:0] ST_LOAD  = 3'd3;
    localparam logic [ST_W-1:0] ST_RUN   = 3'd4;
    localparam logic [ST_W-1:0] ST_PAUSE = 3'd5;

    localparam logic [CNT_W-1:0] MAX_DIGITS = 3'd4;

    logic [ST_W-1:0]  state_q, state_d;
    logic [DIG_W-1:0] mt_q, mt_d;
    logic [DIG_W-1:0] mu_q, mu_d;
    logic [DIG_W-1:0] st_q, st_d;
    logic [DIG_W-1:0] su_q, su_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_n_q, load_n_d;
    logic             enab_q, enab_d;
    logic             done_q, done_d;

    // Input capture stage plus one-flop history per button
    logic             key_in_q, key_prev_q;
    logic             start_in_q, start_prev_q;
    logic             stop_in_q, stop_prev_q;
    logic [DIG_W-1:0] code_q;

    logic key_ev_c, start_ev_c, stop_ev_c;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            key_in_q     <= 1'b0;
            key_prev_q   <= 1'b0;
            start_in_q   <= 1'b0;
            start_prev_q <= 1'b0;
            stop_in_q    <= 1'b0;
            stop_prev_q  <= 1'b0;
            code_q       <= '0;
        end else begin
            key_in_q     <= key_valid;
            key_prev_q   <= key_in_q;
            start_in_q   <= start_key;
            start_prev_q <= start_in_q;
            stop_in_q    <= stop_key;
            stop_prev_q  <= stop_in_q;
            code_q       <= key_code;
        end
    end

    // Events with priority stop > start > digit; codes 10-15 never count as a digit
    always_comb begin
        stop_ev_c  = stop_in_q & ~stop_prev_q;
        start_ev_c = start_in_q & ~start_prev_q & ~stop_ev_c;
        key_ev_c   = key_in_q & ~key_prev_q & ~stop_ev_c & ~start_ev_c
                     & (code_q < 4'd10);
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            mt_q     <= '0;
            mu_q     <= '0;
            st_q     <= '0;
            su_q     <= '0;
            cnt_q    <= '0;
            load_n_q <= 1'b1;
            enab_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mt_q     <= mt_d;
            mu_q     <= mu_d;
            st_q     <= st_d;
            su_q     <= su_d;
            cnt_q    <= cnt_d;
            load_n_q <= load_n_d;
            enab_q   <= enab_d;
            done_q   <= done_d;
        end
    end

    // Next state, buffer and strobes
    always_comb begin
        state_d  = state_q;
        mt_d     = mt_q;
        mu_d     = mu_q;
        st_d     = st_q;
        su_d     = su_q;
        cnt_d    = cnt_q;
        load_n_d = 1'b1;
        enab_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_ev_c) begin
                    mt_d    = mu_q;
                    mu_d    = st_q;
                    st_d    = su_q;
                    su_d    = code_q;
                    cnt_d   = 3'd1;
                    state_d = ST_ENTRY;
                end
            end

            ST_ENTRY: begin
                if (stop_ev_c) begin
                    mt_d    = '0;
                    mu_d    = '0;
                    st_d    = '0;
                    su_d    = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (start_ev_c) begin
                    // Normalized value is registered on entry to NORM so the load
                    // inputs are settled for a full cycle ahead of the strobe.
                    if (st_q >= 4'd6) begin
                        if (mt_q == 4'd9 && mu_q == 4'd9) begin
                            st_d = 4'd5;
                            su_d = 4'd9;
                        end else begin
                            st_d = DIG_W'(st_q - 4'd6);
                            if (mu_q == 4'd9) begin
                                mu_d = '0;
                                mt_d = DIG_W'(mt_q + 4'd1);
                            end else begin
                                mu_d = DIG_W'(mu_q + 4'd1);
                            end
                        end
                    end
                    state_d = ST_NORM;
                end else if (key_ev_c && cnt_q < MAX_DIGITS) begin
                    mt_d  = mu_q;
                    mu_d  = st_q;
                    st_d  = su_q;
                    su_d  = code_q;
                    cnt_d = CNT_W'(cnt_q + 3'd1);
                end
            end

            ST_NORM: begin
                load_n_d = 1'b0;
                state_d  = ST_LOAD;
            end

            ST_LOAD: begin
                enab_d  = 1'b1;
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (timer_zero) begin
                    done_d  = 1'b1;
                    mt_d    = '0;
                    mu_d    = '0;
                    st_d    = '0;
                    su_d    = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (stop_ev_c) begin
                    state_d = ST_PAUSE;
                end else begin
                    enab_d = 1'b1;
                end
            end

            ST_PAUSE: begin
                if (stop_ev_c) begin
                    mt_d    = '0;
                    mu_d    = '0;
                    st_d    = '0;
                    su_d    = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (start_ev_c) begin
                    enab_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end

            default: begin
                mt_d    = '0;
                mu_d    = '0;
                st_d    = '0;
                su_d    = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign min_tens    = mt_q;
    assign min_units   = mu_q;
    assign sec_tens    = st_q;
    assign sec_units   = su_q;
    assign digit_count = cnt_q;
    assign load_n      = load_n_q;
    assign enab        = enab_q;
    assign done        = done_q;

endmodule

// File: tb/tb_time_entry_buffer.sv
// Bench for time_entry_buffer: load/done events checked against a queue of expected
// buffer values, plus direct checks of state after each directed sequence.
module tb_time_entry_buffer;

    logic       clk = 1'b0;
    logic       clear;
    logic       key_valid;
    logic [3:0] key_code;
    logic       start_key;
    logic       stop_key;
    logic       timer_zero;
    logic [3:0] min_tens, min_units, sec_tens, sec_units;
    logic       load_n, enab, done;
    logic [2:0] digit_count;

    typedef struct packed {
        logic        is_done;
        logic [15:0] bcd;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    time_entry_buffer dut (
        .clk        (clk),
        .clear      (clear),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .start_key  (start_key),
        .stop_key   (stop_key),
        .timer_zero (timer_zero),
        .min_tens   (min_tens),
        .min_units  (min_units),
        .sec_tens   (sec_tens),
        .sec_units  (sec_units),
        .load_n     (load_n),
        .enab       (enab),
        .done       (done),
        .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd_now();
        return {min_tens, min_units, sec_tens, sec_units};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key(input logic [3:0] c);
        key_code  = c;
        key_valid = 1'b1;
        tick(2);
        key_valid = 1'b0;
        tick(2);
    endtask

    task automatic press_start();
        start_key = 1'b1;
        tick(2);
        start_key = 1'b0;
        tick(2);
    endtask

    task automatic press_stop();
        stop_key = 1'b1;
        tick(2);
        stop_key = 1'b0;
        tick(2);
    endtask

    // Monitor: every load strobe or done pulse consumes one expected entry
    always @(negedge clk) begin
        if (!clear && (!load_n || done)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: load_n=%b done=%b bcd=%h", load_n, done, bcd_now());
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({done, load_n, bcd_now(), enab} !== {e.is_done, e.is_done, e.bcd, 1'b0}) begin
                    n_err++;
                    $display("FAIL event: got done=%b load_n=%b bcd=%h enab=%b expected done=%b load_n=%b bcd=%h enab=0",
                             done, load_n, bcd_now(), enab, e.is_done, e.is_done, e.bcd);
                end
            end
        end
    end

    initial begin
        clear      = 1'b1;
        key_valid  = 1'b0;
        key_code   = 4'd0;
        start_key  = 1'b0;
        stop_key   = 1'b0;
        timer_zero = 1'b0;
        tick(2);
        check("reset_bcd", 32'(bcd_now()), 32'h0000);
        check("reset_cnt", 32'(digit_count), 32'd0);
        check("reset_strobes", 32'({load_n, enab, done}), 32'b100);
        clear = 1'b0;
        tick(2);

        // Keypress latency: visible on the 2nd rising edge
        key_code  = 4'd1;
        key_valid = 1'b1;
        tick(1);
        check("latency_early", 32'(bcd_now()), 32'h0000);
        tick(1);
        check("latency_update", 32'(bcd_now()), 32'h0001);
        key_valid = 1'b0;
        tick(2);
        press_key(4'd2);
        press_key(4'd3);
        press_key(4'd0);
        check("entry_bcd", 32'(bcd_now()), 32'h1230);
        check("entry_cnt", 32'(digit_count), 32'd4);
        exp_q.push_back('{is_done: 1'b0, bcd: 16'h1230});
        press_start();
        check("run_enab", 32'(enab), 32'd1);
        tick(3);
        check("run_hold", 32'({enab, load_n}), 32'b11);

        // Pause and resume without reload
        press_stop();
        check("pause_enab", 32'(enab), 32'd0);
        check("pause_bcd", 32'(bcd_now()), 32'h1230);
        press_start();
        check("resume_enab", 32'(enab), 32'd1);
        press_stop();
        press_stop();
        check("cancel_bcd", 32'(bcd_now()), 32'h0000);
        check("cancel_cnt", 32'(digit_count), 32'd0);
        check("cancel_enab", 32'(enab), 32'd0);

        // Completion: timer_zero beats a coincident stop event
        press_key(4'd4);
        press_key(4'd5);
        exp_q.push_back('{is_done: 1'b0, bcd: 16'h0045});
        press_start();
        check("run2_enab", 32'(enab), 32'd1);
        exp_q.push_back('{is_done: 1'b1, bcd: 16'h0000});
        stop_key = 1'b1;
        tick(1);
        timer_zero = 1'b1;
        tick(1);
        timer_zero = 1'b0;
        stop_key   = 1'b0;
        tick(2);
        check("done_idle", 32'({enab, done, digit_count}), 32'd0);
        check("done_bcd", 32'(bcd_now()), 32'h0000);
        press_start();
        check("idle_start_ignored", 32'({enab, load_n}), 32'b01);

        // Normalization 00:90 -> 01:30, then clear mid-run
        press_key(4'd9);
        press_key(4'd0);
        exp_q.push_back('{is_done: 1'b0, bcd: 16'h0130});
        press_start();
        check("norm_enab", 32'(enab), 32'd1);
        clear = 1'b1;
        #1;
        check("clr_enab_load", 32'({enab, load_n}), 32'b01);
        check("clr_bcd", 32'(bcd_now()), 32'h0000);
        check("clr_cnt", 32'(digit_count), 32'd0);
        tick(1);
        clear = 1'b0;
        tick(1);

        // Saturation 99:99 -> 99:59
        for (int i = 0; i < 4; i++) press_key(4'd9);
        exp_q.push_back('{is_done: 1'b0, bcd: 16'h9959});
        press_start();
        press_stop();
        press_stop();
        check("sat_cancel", 32'(bcd_now()), 32'h0000);

        // Invalid codes and overflow
        press_key(4'd12);
        check("invalid_idle_cnt", 32'(digit_count), 32'd0);
        press_key(4'd1);
        press_key(4'd2);
        press_key(4'd12);
        check("invalid_entry", 32'({bcd_now(), 1'b0, digit_count}), 32'h00122);
        press_key(4'd3);
        press_key(4'd4);
        press_key(4'd5);
        press_key(4'd12);
        check("overflow_bcd", 32'(bcd_now()), 32'h1234);
        check("overflow_cnt", 32'(digit_count), 32'd4);
        press_stop();
        check("entry_stop", 32'({bcd_now(), 1'b0, digit_count}), 32'h00000);

        // Start and digit in one cycle: start wins, 7 dropped
        press_key(4'd3);
        exp_q.push_back('{is_done: 1'b0, bcd: 16'h0003});
        key_code  = 4'd7;
        key_valid = 1'b1;
        start_key = 1'b1;
        tick(2);
        key_valid = 1'b0;
        start_key = 1'b0;
        tick(2);
        check("prio_enab", 32'(enab), 32'd1);
        check("prio_cnt", 32'(digit_count), 32'd1);
        press_stop();
        press_stop();
        tick(3);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_events: got %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/time_entry_buffer.md
# time_entry_buffer

Upstream feeder for the MS_Timer (MOD10/MOD6 countdown chain). Captures decimal keypad digits into a 4-digit BCD MM:SS buffer and normalizes seconds ≥ 60 into minutes. On START it presents the value on the timer's parallel-load inputs with an active-low load pulse, then drives the timer count enable. It tracks run, pause, cancel and completion using the timer's all-zero flag.

## Interface
- No parameters. Digit count is fixed at 4, widths at 4-bit BCD.
- clk  in  1  system clock; all state updates on its rising edge.
- clear  in  1  reset, asynchronous and active-high. Forces every register and output to its reset value.
- key_valid  in  1  level-high while a keypad key is held. Only a rising edge registers a keypress.
- key_code  in  4  key value, sampled on key_valid rising edge. Values 0–9 are digits; 10–15 are ignored.
- start_key  in  1  level-high start button, rising-edge detected.
- stop_key  in  1  level-high stop/cancel button, rising-edge detected.
- timer_zero  in  1  high when the downstream timer reads 00:00.
- min_tens, min_units, sec_tens, sec_units  out  4 each  BCD buffer; these drive the timer's parallel-load inputs.
- load_n  out  1  active-low parallel-load strobe to the timer; low for exactly one cycle.
- enab  out  1  timer count enable.
- done  out  1  one-cycle pulse when a run reaches zero.
- digit_count  out  3  number of digits entered, 0–4.

## Operation
- Edge detect: key_valid, start_key and stop_key each have a one-flop history; an event is input high and history low. All histories reset to 0.
- Event priority in one cycle: stop > start > digit. Lower-priority events in the same cycle are dropped.
- States: IDLE, ENTRY, NORM, LOAD, RUN, PAUSE.
- IDLE
  - Buffer is 00:00, digit_count = 0.
  - Valid digit: shift it in, go to ENTRY.
  - Start and stop are ignored.
- ENTRY
  - Valid digit with digit_count < 4: shift left (min_tens←min_units←sec_tens←sec_units←digit), digit_count += 1.
  - Digit when digit_count = 4: ignored, buffer unchanged.
  - Start: go to NORM.
  - Stop: zero the buffer, digit_count = 0, go to IDLE.
- NORM (1 cycle)
  - S = sec_tens*10 + sec_units.
  - If S ≥ 60: sec = S − 60, minutes += 1.
  - If minutes were already 99, saturate to 99:59.
  - Results are written back as BCD. Go to LOAD.
- LOAD (1 cycle): load_n = 0, go to RUN.
- RUN
  - enab = 1; digits ignored.
  - timer_zero: enab = 0 that cycle, done = 1, zero the buffer, digit_count = 0, go to IDLE.
  - Stop: go to PAUSE.
  - If stop and timer_zero arrive together, timer_zero wins.
- PAUSE
  - enab = 0; buffer holds.
  - Start: back to RUN with no reload.
  - Stop: zero the buffer, go to IDLE.
  - Digits ignored.
- Invalid key_code (≥10) on a key edge is ignored in every state.
- BCD arithmetic stays within 0–9 per digit; an entered sec_tens up to 9 is legal before NORM.

## Timing
- Reset values: state = IDLE, all digits = 0, digit_count = 0, load_n = 1, enab = 0, done = 0.
- All outputs are registered.
- Keypress to buffer update: 1 cycle after the input rises (edge flop) plus 1 register cycle. The visible change is on the 2nd rising edge after the input rises.
- Start to load_n low: start edge → NORM → LOAD. load_n is low during the 3rd cycle after the start-edge detection edge. enab rises the following cycle.
- Buffer digits are stable for the whole LOAD cycle and the cycle before it.
- done and the enab drop appear the cycle after timer_zero is sampled high in RUN.
- clear asserted mid-RUN: enab drops immediately (asynchronously), load_n goes to 1, and the buffer is zeroed. The timer is not reloaded.

## Test plan
- Reset: assert clear mid-RUN → enab = 0, load_n = 1, buffer 00:00, digit_count = 0 immediately.
- Entry: keys 1, 2, 3, 0, then start → buffer 12:30; one load_n low pulse; enab = 1 thereafter.
- Normalization: keys 9, 0, start → buffer 01:30 at load. Keys 9, 9, 9, 9, start → saturated to 99:59.
- Overflow and invalid keys: keys 1, 2, 3, 4, 5, plus code 12 → buffer 12:34, digit_count = 4.
- Pause and resume: stop in RUN → enab = 0, buffer held. Start → enab = 1 with no load_n pulse. Stop twice → IDLE, 00:00.
- Completion and priority: timer_zero with stop in RUN → done pulse, IDLE. Start and digit 7 in one ENTRY cycle → NORM entered, 7 dropped.
